// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 definitions: icodes, status codes, memory-stage
//               FSM encoding and icode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] c_ICODE_HALT   = 4'h0;
    localparam logic [3:0] c_ICODE_NOP    = 4'h1;
    localparam logic [3:0] c_ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] c_ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] c_ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] c_ICODE_OPQ    = 4'h6;
    localparam logic [3:0] c_ICODE_JXX    = 4'h7;
    localparam logic [3:0] c_ICODE_CALL   = 4'h8;
    localparam logic [3:0] c_ICODE_RET    = 4'h9;
    localparam logic [3:0] c_ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] c_ICODE_POPQ   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    function automatic logic f_is_mem(input logic [3:0] icode);
        return (icode == c_ICODE_RMMOVQ) || (icode == c_ICODE_MRMOVQ) ||
               (icode == c_ICODE_CALL)   || (icode == c_ICODE_RET)    ||
               (icode == c_ICODE_PUSHQ)  || (icode == c_ICODE_POPQ);
    endfunction

    function automatic logic f_is_read(input logic [3:0] icode);
        return (icode == c_ICODE_MRMOVQ) || (icode == c_ICODE_RET) ||
               (icode == c_ICODE_POPQ);
    endfunction

    function automatic logic f_is_write(input logic [3:0] icode);
        return (icode == c_ICODE_RMMOVQ) || (icode == c_ICODE_CALL) ||
               (icode == c_ICODE_PUSHQ);
    endfunction

    // ret/popq address the stack through valA; every other memory op uses valE.
    function automatic logic f_addr_from_vala(input logic [3:0] icode);
        return (icode == c_ICODE_RET) || (icode == c_ICODE_POPQ);
    endfunction

    function automatic stat_e f_status(input logic fault, input logic halt,
                                       input logic instr_valid);
        if (fault)             return STAT_ADR;
        else if (halt)         return STAT_HLT;
        else if (!instr_valid) return STAT_INS;
        else                   return STAT_AOK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte-addressable data memory, synchronous 8-byte little-endian
//               write and combinational 8-byte little-endian read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [$clog2(MEM_BYTES)-1:0] addr_i,
    input  logic [63:0]                  wdata_i,
    output logic [63:0]                  rdata_o
);
    import y86_pkg::*;

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem_q [0:MEM_BYTES-1];
    logic [AW-1:0] w_idx [0:7];
    logic [7:0]    w_ok;

    // Lanes past the top of a non power-of-two array are masked off.
    generate
        for (genvar k = 0; k < 8; k++) begin : g_lane
            assign w_idx[k] = addr_i + AW'(k);
            assign w_ok[k]  = (32'(w_idx[k]) < 32'(MEM_BYTES));
            assign rdata_o[8*k +: 8] = w_ok[k] ? mem_q[w_idx[k]] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < 8; k++) begin
                if (w_ok[k]) mem_q[w_idx[k]] <= wdata_i[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Y86-64 sequential-core memory stage with start/done handshake,
//               configurable access latency, fault detection and status.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int MEM_BYTES   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        halt_prog,
    input  logic        instr_valid,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [2:0]  stat
);
    import y86_pkg::*;

    localparam int          AW         = $clog2(MEM_BYTES);
    localparam logic [63:0] c_ADDR_MAX = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  c_CNT_LAST = 4'(MEM_LATENCY - 1);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] valm_q, valm_d;
    logic        err_q, err_d;
    stat_e       stat_q, stat_d;

    logic [3:0]  icode_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic        halt_q;
    logic        ivalid_q;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_fault;
    logic        w_real;
    logic        w_last;
    logic        w_we;
    logic [63:0] w_rdata;

    assign w_is_mem = f_is_mem(icode_q);
    // Unsigned 64-bit compare: huge addresses cannot wrap back into range.
    assign w_fault  = w_is_mem && (addr_q > c_ADDR_MAX);
    assign w_real   = w_is_mem && !w_fault;
    assign w_last   = (cnt_q == c_CNT_LAST);
    assign w_we     = (state_q == ST_ACCESS) && w_real && f_is_write(icode_q)
                      && w_last && !reset;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valm_d   = valm_q;
        err_d    = err_q;
        stat_d   = stat_q;
        w_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!w_real || w_last) begin
                    state_d = ST_DONE;
                    err_d   = w_fault;
                    stat_d  = f_status(w_fault, halt_q, ivalid_q);
                    if (w_fault)
                        valm_d = 64'd0;
                    else if (f_is_read(icode_q))
                        valm_d = w_rdata;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            valm_q   <= 64'd0;
            err_q    <= 1'b0;
            stat_q   <= STAT_AOK;
            icode_q  <= c_ICODE_NOP;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            halt_q   <= 1'b0;
            ivalid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
            stat_q  <= stat_d;
            if (w_accept) begin
                icode_q  <= icode;
                addr_q   <= f_addr_from_vala(icode) ? valA : valE;
                wdata_q  <= (icode == c_ICODE_CALL) ? valP : valA;
                halt_q   <= halt_prog;
                ivalid_q <= instr_valid;
            end
        end
    end

    data_memory #(
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_we),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (w_rdata)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign valM       = valm_q;
    assign dmem_error = err_q;
    assign stat       = stat_q;

endmodule
`default_nettype wire

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory stage of the sequential Y86-64 core. It sits directly downstream of Execute and upstream of decode/writeback.
- Consumes icode, valE, valA and valP. Performs the data-memory read or write for rmmovq, mrmovq, call, ret, pushq and popq.
- Returns valM and the processor status code.
- Multi-cycle: a start/done handshake with a configurable access latency. The PC-update logic holds PC until done.

Parameters:
- MEM_BYTES, 1024, size of byte-addressable data memory; valid byte addresses are 0..MEM_BYTES-1.
- MEM_LATENCY, 2, cycles spent in ACCESS for a real memory op; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- icode  input  4  instruction code, captured at accepted start
- valE  input  64  ALU result (address for rmmovq/mrmovq/call/pushq)
- valA  input  64  register A (write data, or address for ret/popq)
- valP  input  64  next-PC (write data for call)
- halt_prog  input  1  fetch saw halt
- instr_valid  input  1  fetch decoded a valid instruction
- busy  output  1  high while the request is in ACCESS or DONE
- done  output  1  one-cycle pulse; valM and stat are valid from this cycle
- valM  output  64  read data (little-endian, 8 bytes)
- dmem_error  output  1  address fault on the last request
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS

Behaviour:
- Reset values:
  - State is IDLE.
  - busy=0, done=0, valM=0, dmem_error=0, stat=1 (AOK).
  - Memory contents are not cleared by reset.
- Address selection:
  - icode 4 (rmmovq), 5 (mrmovq), 8 (call), A (pushq): addr = valE.
  - icode 9 (ret), B (popq): addr = valA.
  - Any other icode is non-memory.
- Write data: valA for icode 4 and A; valP for icode 8.
- Reads are performed for icode 5, 9 and B.
- Fault:
  - Condition: addr > MEM_BYTES-8, using unsigned 64-bit compare, so no wrap-around is possible.
  - A faulting request performs no write and returns valM=0.
- State machine:
  - IDLE: on start, capture icode, addr, wdata, halt_prog and instr_valid; go to ACCESS. busy asserts the next cycle.
  - ACCESS, non-memory op or fault: go to DONE after 1 cycle.
  - ACCESS, memory op: count MEM_LATENCY cycles. On the last cycle, commit the write (bytes addr..addr+7, LSB at addr) or latch the read into valM. Then go to DONE.
  - DONE: pulse done=1 with valM, dmem_error and stat updated. Return to IDLE the next cycle.
- Latency: start accepted at cycle 0 gives done at cycle 2 (non-memory or fault) or cycle MEM_LATENCY+1 (memory op).
- Hold rules:
  - valM holds its value until the next read completes.
  - A non-memory op or a write leaves valM unchanged.
- Status priority at DONE: dmem_error → 3; else halt → 2; else !instr_valid → 4; else 1.
- Simultaneous events:
  - start while busy is ignored; there is no queueing.
  - start in the same cycle done pulses is ignored; it must be reissued once in IDLE.
- Reset mid-operation:
  - The next edge returns to IDLE.
  - An uncommitted write is dropped; a write already committed stays.
  - Outputs return to reset values.
- Captured operands are registered at accept, so input changes during busy have no effect.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT=0 … POPQ=B).
  - stat codes AOK/HLT/ADR/INS.
  - FSM state encoding IDLE/ACCESS/DONE.
- Sub-module data_memory:
  - Byte array of MEM_BYTES.
  - Synchronous 8-byte little-endian write on we.
  - Combinational 8-byte little-endian read.
  - memory_stage owns the FSM, latency counter, fault check and status.

Test Plan:
- Reset, then rmmovq: icode=4, valE=16, valA=0x1122334455667788, start.
  - Response: done at cycle 3 (MEM_LATENCY=2); memory bytes 16..23 = 88,77,…,11; stat=1.
- mrmovq read-back: icode=5, valE=16.
  - Response: done at cycle 3; valM=0x1122334455667788; dmem_error=0.
- call/ret: icode=8, valE=1000, valP=33, then icode=9, valA=1000.
  - Response: second done gives valM=33.
- Fault: icode=B with valA=1017, then icode=5 with valE=0xFFFFFFFFFFFFFFF8.
  - Response: done at cycle 2; dmem_error=1; stat=3; valM=0; no memory bytes change.
- Non-memory and status:
  - icode=6 with instr_valid=1 → done at cycle 2, stat=1, valM unchanged.
  - icode=0 with halt_prog=1 → stat=2.
  - instr_valid=0 → stat=4.
- Robustness:
  - Assert start while busy → ignored.
  - Assert reset in cycle 1 of a rmmovq to address 40 → next cycle IDLE, busy=0; bytes 40..47 unchanged.
